// File: rtl/wb_pipe_reg.sv
// +--------------------------------------------------------------------------+
// | wb_pipe_reg                                                              |
// | MEM/WB pipeline register with valid/ready flow control, flush and an     |
// | optional two-entry skid buffer.                                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [DATA_W-1:0] RD,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [REG_AW-1:0] WriteRegM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW
);

  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

  // Main entry: always drives the W outputs.
  logic              r_mValid;
  logic              r_mRegWrite;
  logic              r_mMemtoReg;
  logic [DATA_W-1:0] r_mReadData;
  logic [DATA_W-1:0] r_mAluOut;
  logic [REG_AW-1:0] r_mWriteReg;

  logic w_accept;

  assign w_accept = in_valid & in_ready & ~flush;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_sValid;
      logic              r_sRegWrite;
      logic              r_sMemtoReg;
      logic [DATA_W-1:0] r_sReadData;
      logic [DATA_W-1:0] r_sAluOut;
      logic [REG_AW-1:0] r_sWriteReg;

      // Skid valid is a flop, so in_ready has no path from out_ready.
      assign in_ready = ~r_sValid;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_mValid    <= 1'b0;
          r_mRegWrite <= 1'b0;
          r_mMemtoReg <= 1'b0;
          r_mReadData <= '0;
          r_mAluOut   <= '0;
          r_mWriteReg <= '0;
          r_sValid    <= 1'b0;
          r_sRegWrite <= 1'b0;
          r_sMemtoReg <= 1'b0;
          r_sReadData <= '0;
          r_sAluOut   <= '0;
          r_sWriteReg <= '0;
        end else if (flush) begin
          r_mValid <= 1'b0;
          r_sValid <= 1'b0;
        end else if (!r_mValid || out_ready) begin
          if (r_sValid) begin
            r_mValid    <= 1'b1;
            r_mRegWrite <= r_sRegWrite;
            r_mMemtoReg <= r_sMemtoReg;
            r_mReadData <= r_sReadData;
            r_mAluOut   <= r_sAluOut;
            r_mWriteReg <= r_sWriteReg;
            if (w_accept) begin
              r_sRegWrite <= RegWriteM;
              r_sMemtoReg <= MemtoRegM;
              r_sReadData <= RD;
              r_sAluOut   <= ALUOutM;
              r_sWriteReg <= WriteRegM;
            end else begin
              r_sValid <= 1'b0;
            end
          end else if (w_accept) begin
            r_mValid    <= 1'b1;
            r_mRegWrite <= RegWriteM;
            r_mMemtoReg <= MemtoRegM;
            r_mReadData <= RD;
            r_mAluOut   <= ALUOutM;
            r_mWriteReg <= WriteRegM;
          end else begin
            r_mValid <= 1'b0;
          end
        end else if (w_accept) begin
          r_sValid    <= 1'b1;
          r_sRegWrite <= RegWriteM;
          r_sMemtoReg <= MemtoRegM;
          r_sReadData <= RD;
          r_sAluOut   <= ALUOutM;
          r_sWriteReg <= WriteRegM;
        end
      end
    end else begin : g_single
      assign in_ready = out_ready | ~r_mValid;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_mValid    <= 1'b0;
          r_mRegWrite <= 1'b0;
          r_mMemtoReg <= 1'b0;
          r_mReadData <= '0;
          r_mAluOut   <= '0;
          r_mWriteReg <= '0;
        end else if (flush) begin
          r_mValid <= 1'b0;
        end else if (w_accept) begin
          r_mValid    <= 1'b1;
          r_mRegWrite <= RegWriteM;
          r_mMemtoReg <= MemtoRegM;
          r_mReadData <= RD;
          r_mAluOut   <= ALUOutM;
          r_mWriteReg <= WriteRegM;
        end else if (out_ready) begin
          r_mValid <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid = r_mValid;
  assign RegWriteW = r_mValid & r_mRegWrite & (r_mWriteReg != c_REG_ZERO);
  assign MemtoRegW = r_mMemtoReg;
  assign ReadDataW = r_mReadData;
  assign ALUOutW   = r_mAluOut;
  assign WriteRegW = r_mWriteReg;
  assign ResultW   = r_mMemtoReg ? r_mReadData : r_mAluOut;

endmodule

`default_nettype wire

// File: tb/tb_wb_pipe_reg.sv
// +--------------------------------------------------------------------------+
// | tb_wb_pipe_reg                                                           |
// | Bench for wb_pipe_reg: SKID=1/32-bit and SKID=0/64-bit instances.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1, DATA_W=32, REG_AW=5 instance
  logic        rstN, flush, inValid, inReady, regWriteM, memtoRegM, outValid, outReady;
  logic        regWriteW, memtoRegW;
  logic [31:0] rd, aluOutM, readDataW, aluOutW, resultW;
  logic [4:0]  writeRegM, writeRegW;

  wb_pipe_reg #(.DATA_W(32), .REG_AW(5), .SKID(1)) dut (
    .clk(clk), .rst_n(rstN), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .RegWriteM(regWriteM), .MemtoRegM(memtoRegM), .RD(rd), .ALUOutM(aluOutM),
    .WriteRegM(writeRegM), .out_valid(outValid), .out_ready(outReady),
    .RegWriteW(regWriteW), .MemtoRegW(memtoRegW), .ReadDataW(readDataW),
    .ALUOutW(aluOutW), .WriteRegW(writeRegW), .ResultW(resultW)
  );

  // SKID=0, DATA_W=64, REG_AW=6 instance
  logic        rstN0, flush0, inValid0, inReady0, regWriteM0, memtoRegM0, outValid0, outReady0;
  logic        regWriteW0, memtoRegW0;
  logic [63:0] rd0, aluOutM0, readDataW0, aluOutW0, resultW0;
  logic [5:0]  writeRegM0, writeRegW0;

  wb_pipe_reg #(.DATA_W(64), .REG_AW(6), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rstN0), .flush(flush0), .in_valid(inValid0), .in_ready(inReady0),
    .RegWriteM(regWriteM0), .MemtoRegM(memtoRegM0), .RD(rd0), .ALUOutM(aluOutM0),
    .WriteRegM(writeRegM0), .out_valid(outValid0), .out_ready(outReady0),
    .RegWriteW(regWriteW0), .MemtoRegW(memtoRegW0), .ReadDataW(readDataW0),
    .ALUOutW(aluOutW0), .WriteRegW(writeRegW0), .ResultW(resultW0)
  );

  typedef struct {
    logic        fl, iv, rw, m2r;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
    logic        ordy;
    logic        eOv, eIr, eRw;
    logic [31:0] eAlu, eRes;
    logic        chkData;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passes++;
  endtask

  task automatic addVec(input logic fl, input logic iv, input logic rw, input logic m2r,
                        input logic [31:0] rdv, input logic [31:0] alu, input logic [4:0] wr,
                        input logic ordy, input logic eOv, input logic eIr, input logic eRw,
                        input logic [31:0] eAlu, input logic [31:0] eRes, input logic chkData);
    vec_t v;
    v.fl = fl; v.iv = iv; v.rw = rw; v.m2r = m2r; v.rd = rdv; v.alu = alu; v.wr = wr;
    v.ordy = ordy; v.eOv = eOv; v.eIr = eIr; v.eRw = eRw; v.eAlu = eAlu; v.eRes = eRes;
    v.chkData = chkData;
    vecs.push_back(v);
  endtask

  initial begin
    // fl iv rw m2r rd alu wr ordy | eOv eIr eRw eAlu eRes chkData
    // stream
    addVec(0,1,1,0,32'h0,32'h10,5'd3,1, 1,1,1,32'h10,32'h10,1);
    addVec(0,1,1,0,32'h0,32'h20,5'd3,1, 1,1,1,32'h20,32'h20,1);
    addVec(0,1,1,0,32'h0,32'h30,5'd3,1, 1,1,1,32'h30,32'h30,1);
    addVec(0,1,1,0,32'h0,32'h40,5'd3,1, 1,1,1,32'h40,32'h40,1);
    addVec(0,0,1,0,32'h0,32'h0, 5'd3,1, 0,1,0,32'h0, 32'h0, 0);
    // stall into skid, C rejected while full, then drain in order
    addVec(0,1,1,0,32'h0,32'hA,5'd3,0, 1,1,1,32'hA,32'hA,1);
    addVec(0,1,1,0,32'h0,32'hB,5'd3,0, 1,0,1,32'hA,32'hA,1);
    addVec(0,1,1,0,32'h0,32'hC,5'd3,0, 1,0,1,32'hA,32'hA,1);
    addVec(0,1,1,0,32'h0,32'hC,5'd3,1, 1,1,1,32'hB,32'hB,1);
    addVec(0,1,1,0,32'h0,32'hC,5'd3,1, 1,1,1,32'hC,32'hC,1);
    addVec(0,0,1,0,32'h0,32'h0,5'd3,1, 0,1,0,32'h0,32'h0,0);
    // result select
    addVec(0,1,1,1,32'hDEADBEEF,32'h1234,5'd3,1, 1,1,1,32'h1234,32'hDEADBEEF,1);
    addVec(0,1,1,0,32'hDEADBEEF,32'h1234,5'd3,1, 1,1,1,32'h1234,32'h1234,1);
    // register-0 suppression and plain RegWrite=0
    addVec(0,1,1,0,32'h0,32'h55,5'd0,1, 1,1,0,32'h55,32'h55,1);
    addVec(0,1,1,0,32'h0,32'h66,5'd5,1, 1,1,1,32'h66,32'h66,1);
    addVec(0,1,0,0,32'h0,32'h77,5'd5,1, 1,1,0,32'h77,32'h77,1);
    addVec(0,0,0,0,32'h0,32'h0,5'd5,1, 0,1,0,32'h0,32'h0,0);
    // flush with both entries full and in_valid high
    addVec(0,1,1,0,32'h0,32'h81,5'd5,0, 1,1,1,32'h81,32'h81,1);
    addVec(0,1,1,0,32'h0,32'h82,5'd5,0, 1,0,1,32'h81,32'h81,1);
    addVec(1,1,1,0,32'h0,32'h83,5'd5,0, 0,1,0,32'h0,32'h0,0);
    addVec(0,0,1,0,32'h0,32'h0,5'd5,1, 0,1,0,32'h0,32'h0,0);
    addVec(0,1,1,0,32'h0,32'h90,5'd5,1, 1,1,1,32'h90,32'h90,1);
    addVec(0,0,1,0,32'h0,32'h0,5'd5,1, 0,1,0,32'h0,32'h0,0);

    rstN = 0; flush = 0; inValid = 0; regWriteM = 0; memtoRegM = 0;
    rd = '0; aluOutM = '0; writeRegM = '0; outReady = 1;
    rstN0 = 0; flush0 = 0; inValid0 = 0; regWriteM0 = 0; memtoRegM0 = 0;
    rd0 = '0; aluOutM0 = '0; writeRegM0 = '0; outReady0 = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1; rstN0 = 1;
    chk("rst_out_valid", {63'd0, outValid}, 64'd0);
    chk("rst_regwrite", {63'd0, regWriteW}, 64'd0);
    chk("rst_in_ready", {63'd0, inReady}, 64'd1);
    chk("rst_result", {32'd0, resultW}, 64'd0);
    chk("rst_writereg", {59'd0, writeRegW}, 64'd0);
    chk("rst0_out_valid", {63'd0, outValid0}, 64'd0);
    chk("rst0_in_ready", {63'd0, inReady0}, 64'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      flush = vecs[i].fl; inValid = vecs[i].iv; regWriteM = vecs[i].rw;
      memtoRegM = vecs[i].m2r; rd = vecs[i].rd; aluOutM = vecs[i].alu;
      writeRegM = vecs[i].wr; outReady = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {63'd0, outValid}, {63'd0, vecs[i].eOv});
      chk($sformatf("v%0d_in_ready", i), {63'd0, inReady}, {63'd0, vecs[i].eIr});
      chk($sformatf("v%0d_regwrite", i), {63'd0, regWriteW}, {63'd0, vecs[i].eRw});
      if (vecs[i].chkData) begin
        chk($sformatf("v%0d_aluout", i), {32'd0, aluOutW}, {32'd0, vecs[i].eAlu});
        chk($sformatf("v%0d_result", i), {32'd0, resultW}, {32'd0, vecs[i].eRes});
      end
    end

    // Reset with both entries held
    @(negedge clk);
    flush = 0; inValid = 1; regWriteM = 1; memtoRegM = 1; rd = 32'hE0;
    aluOutM = 32'hE1; writeRegM = 5'd7; outReady = 0;
    @(negedge clk);
    aluOutM = 32'hE2;
    @(posedge clk); #1;
    chk("rstmid_full_in_ready", {63'd0, inReady}, 64'd0);
    @(negedge clk);
    rstN = 0; inValid = 0;
    @(posedge clk); #1;
    chk("rstmid_out_valid", {63'd0, outValid}, 64'd0);
    chk("rstmid_regwrite", {63'd0, regWriteW}, 64'd0);
    chk("rstmid_memtoreg", {63'd0, memtoRegW}, 64'd0);
    chk("rstmid_readdata", {32'd0, readDataW}, 64'd0);
    chk("rstmid_aluout", {32'd0, aluOutW}, 64'd0);
    chk("rstmid_writereg", {59'd0, writeRegW}, 64'd0);
    chk("rstmid_result", {32'd0, resultW}, 64'd0);
    chk("rstmid_in_ready", {63'd0, inReady}, 64'd1);
    @(negedge clk);
    rstN = 1; outReady = 1;
    @(posedge clk); #1;
    chk("rstmid_no_leak", {63'd0, outValid}, 64'd0);

    // SKID=0, 64-bit instance: comb in_ready, wide fields, reset mid-stall
    @(negedge clk);
    inValid0 = 1; regWriteM0 = 1; memtoRegM0 = 1; rd0 = 64'hFFFF_0000_FFFF_0001;
    aluOutM0 = 64'h1234_5678_9ABC_DEF0; writeRegM0 = 6'd40; outReady0 = 0;
    #1 chk("s0_in_ready_empty", {63'd0, inReady0}, 64'd1);
    @(posedge clk); #1;
    chk("s0_out_valid", {63'd0, outValid0}, 64'd1);
    chk("s0_regwrite", {63'd0, regWriteW0}, 64'd1);
    chk("s0_result", resultW0, 64'hFFFF_0000_FFFF_0001);
    chk("s0_aluout", aluOutW0, 64'h1234_5678_9ABC_DEF0);
    chk("s0_writereg", {58'd0, writeRegW0}, 64'd40);
    chk("s0_in_ready_stall", {63'd0, inReady0}, 64'd0);
    outReady0 = 1;
    #1 chk("s0_in_ready_comb", {63'd0, inReady0}, 64'd1);
    @(negedge clk);
    memtoRegM0 = 0; aluOutM0 = 64'hAAAA_BBBB_CCCC_DDDD; writeRegM0 = 6'd0;
    @(posedge clk); #1;
    chk("s0_stream_alu", aluOutW0, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("s0_reg0_regwrite", {63'd0, regWriteW0}, 64'd0);
    chk("s0_stream_valid", {63'd0, outValid0}, 64'd1);
    @(negedge clk);
    outReady0 = 0; aluOutM0 = 64'h5555; writeRegM0 = 6'd9;
    @(posedge clk); #1;
    chk("s0_hold_alu", aluOutW0, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk);
    rstN0 = 0; inValid0 = 0;
    @(posedge clk); #1;
    chk("s0_rst_out_valid", {63'd0, outValid0}, 64'd0);
    chk("s0_rst_aluout", aluOutW0, 64'd0);
    chk("s0_rst_readdata", readDataW0, 64'd0);
    chk("s0_rst_result", resultW0, 64'd0);
    chk("s0_rst_writereg", {58'd0, writeRegW0}, 64'd0);
    chk("s0_rst_memtoreg", {63'd0, memtoRegW0}, 64'd0);
    chk("s0_rst_regwrite", {63'd0, regWriteW0}, 64'd0);
    @(negedge clk);
    rstN0 = 1;
    #1 chk("s0_rst_in_ready", {63'd0, inReady0}, 64'd1);
    @(negedge clk);
    inValid0 = 1; flush0 = 1; aluOutM0 = 64'h77;
    @(posedge clk); #1;
    chk("s0_flush_drop", {63'd0, outValid0}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
